// File: rtl/bcd_decoder_arbiter.sv
// Round-robin arbiter sharing one BCD-to-one-hot decoder among N_REQ requesters.
// Optional macro BCD_DECODER_ARBITER_DIGIT_CHECK_EN rejects digits >9 through a one-cycle ERR state.
module bcd_decoder_arbiter #(
  parameter int N_REQ       = 4,
  parameter int HOLD_CYCLES = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req,
  input  logic [4*N_REQ-1:0]   bcd_in,
  output logic [3:0]           dec_in,
  output logic [N_REQ-1:0]     grant,
  output logic [N_REQ-1:0]     done,
  output logic                 busy,
  output logic                 err
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [IDX_W-1:0] PTR_RST  = IDX_W'(N_REQ - 1);
  localparam logic [3:0]       DEC_OFF  = 4'hF;

`ifdef BCD_DECODER_ARBITER_DIGIT_CHECK_EN
  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_ERR} state_t;
`else
  typedef enum logic {S_IDLE, S_HOLD} state_t;
`endif

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] win;
  logic [CNT_W-1:0] cnt;

  logic [IDX_W:0]   pick;
  logic             found;
  logic [IDX_W-1:0] cand;
  logic [3:0]       cand_dig;
  logic [N_REQ-1:0] cand_oh;

  // Search from ptr+1 upward; walking k downward lets the nearest hit win.
  function automatic logic [IDX_W:0] rr_pick(input logic [N_REQ-1:0] r,
                                             input logic [IDX_W-1:0] p);
    logic [IDX_W:0] res;
    int             c;
    res = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      c = (int'(p) + k) % N_REQ;
      if (r[c[IDX_W-1:0]]) res = {1'b1, c[IDX_W-1:0]};
    end
    return res;
  endfunction

  assign pick     = rr_pick(req, ptr);
  assign found    = pick[IDX_W];
  assign cand     = pick[IDX_W-1:0];
  assign cand_dig = bcd_in[{cand, 2'b00} +: 4];
  assign cand_oh  = N_REQ'(1) << cand;

`ifndef BCD_DECODER_ARBITER_DIGIT_CHECK_EN
  assign err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      ptr    <= PTR_RST;
      win    <= '0;
      cnt    <= '0;
      grant  <= '0;
      done   <= '0;
      busy   <= 1'b0;
      dec_in <= DEC_OFF;
`ifdef BCD_DECODER_ARBITER_DIGIT_CHECK_EN
      err    <= 1'b0;
`endif
    end else begin
      done <= '0;
`ifdef BCD_DECODER_ARBITER_DIGIT_CHECK_EN
      err  <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (found) begin
            win   <= cand;
            grant <= cand_oh;
            busy  <= 1'b1;
`ifdef BCD_DECODER_ARBITER_DIGIT_CHECK_EN
            if (cand_dig > 4'd9) begin
              state  <= S_ERR;
              dec_in <= DEC_OFF;
              err    <= 1'b1;
              done   <= cand_oh;
            end else
`endif
            begin
              state  <= S_HOLD;
              dec_in <= cand_dig;
              cnt    <= CNT_LOAD;
              // A single-cycle dwell completes in the very cycle it starts.
              if (HOLD_CYCLES == 1) done <= cand_oh;
            end
          end
        end
        S_HOLD: begin
          if (cnt == '0) begin
            state  <= S_IDLE;
            ptr    <= win;
            grant  <= '0;
            busy   <= 1'b0;
            dec_in <= DEC_OFF;
          end else begin
            cnt <= cnt - 1'b1;
            // done is registered, so it is raised one edge before cnt reaches 0.
            if (cnt == CNT_W'(1)) done <= grant;
          end
        end
`ifdef BCD_DECODER_ARBITER_DIGIT_CHECK_EN
        S_ERR: begin
          state  <= S_IDLE;
          ptr    <= win;
          grant  <= '0;
          busy   <= 1'b0;
          dec_in <= DEC_OFF;
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_decoder_arbiter.sv
// Directed bench for bcd_decoder_arbiter: expected grants are queued on stimulus and
// checked by a negedge monitor when the DUT serves them.
module tb_bcd_decoder_arbiter;
  localparam int N_REQ = 4;
  localparam int HOLD  = 8;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [N_REQ-1:0]   req = '0;
  logic [4*N_REQ-1:0] bcd_in = '0;
  logic [3:0]         dec_in;
  logic [N_REQ-1:0]   grant;
  logic [N_REQ-1:0]   done;
  logic               busy;
  logic               err;

  bcd_decoder_arbiter #(.N_REQ(N_REQ), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .rst(rst), .req(req), .bcd_in(bcd_in),
    .dec_in(dec_in), .grant(grant), .done(done), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         idx;
    logic [3:0] dig;
    int         len;
    logic       e;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   mlen    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input int idx, input logic [3:0] dig, input int len, input logic e);
    exp_t t;
    t.idx = idx; t.dig = dig; t.len = len; t.e = e;
    return t;
  endfunction

  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (done == '0 && cyc < 40);
    check("done_seen", done != '0, 1);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst) begin
      mlen = 0;
    end else if (grant != '0) begin
      mlen++;
      if (exp_q.size() == 0) begin
        check("unexpected_grant", grant, 0);
      end else begin
        check("grant", grant, 32'd1 << exp_q[0].idx);
        check("dec_in", dec_in, exp_q[0].dig);
        check("busy", busy, 1);
        check("err", err, (done != '0) ? exp_q[0].e : 1'b0);
        if (done != '0) begin
          check("done", done, 32'd1 << exp_q[0].idx);
          check("dwell", mlen, exp_q[0].len);
          void'(exp_q.pop_front());
          mlen = 0;
        end
      end
    end else begin
      check("idle_done", done, 0);
      check("idle_err", err, 0);
      check("idle_dec", dec_in, 4'hF);
      check("idle_busy", busy, 0);
      mlen = 0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    logic seen;

    // Reset with every requester asking
    req    = 4'b1111;
    bcd_in = {4'd9, 4'd0, 4'd5, 4'd3};
    @(posedge clk);
    repeat (3) begin
      @(negedge clk);
      check("rst_grant", grant, 0);
      check("rst_dec", dec_in, 4'hF);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
    end
    exp_q.push_back(mk(0, 4'd3, HOLD, 1'b0));
    exp_q.push_back(mk(1, 4'd5, HOLD, 1'b0));
    exp_q.push_back(mk(2, 4'd0, HOLD, 1'b0));
    exp_q.push_back(mk(3, 4'd9, HOLD, 1'b0));
    exp_q.push_back(mk(0, 4'd3, HOLD, 1'b0));
    rst = 1'b0;

    // Contention: round-robin 0,1,2,3,0 at one grant per HOLD+1 cycles
    wait_done(c);
    repeat (3) begin
      wait_done(c);
      check("rr_period", c, HOLD + 1);
    end
    repeat (3) @(negedge clk);
    req = '0;
    wait_done(c);
    check("rr_period_last", c + 3, HOLD + 1);
    repeat (2) @(negedge clk);

    // Single requester, latency and dwell
    req = 4'b0100;
    bcd_in[11:8] = 4'd7;
    exp_q.push_back(mk(2, 4'd7, HOLD, 1'b0));
    @(negedge clk);
    check("single_latency", grant, 4'b0100);
    req = '0;
    wait_done(c);
    check("single_done_cycle", c, HOLD - 1);
    @(negedge clk);
    check("single_after_grant", grant, 0);
    check("single_after_dec", dec_in, 4'hF);

    // Digit and request are latched at grant
    req = 4'b0001;
    bcd_in[3:0] = 4'd2;
    exp_q.push_back(mk(0, 4'd2, HOLD, 1'b0));
    repeat (3) @(negedge clk);
    bcd_in[3:0] = 4'd6;
    req = '0;
    wait_done(c);
    check("latch_done_cycle", c, HOLD - 3);
    @(negedge clk);

    // Reset during HOLD cycle 4 aborts without done
    req = 4'b0010;
    bcd_in[7:4] = 4'd4;
    exp_q.push_back(mk(1, 4'd4, HOLD, 1'b0));
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_grant", grant, 0);
    check("abort_dec", dec_in, 4'hF);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    rst = 1'b0;
    req = '0;
    exp_q.delete();
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      seen = seen | (done != '0);
    end
    check("abort_no_done", seen, 0);

    // Out-of-range digit
    req = 4'b0010;
    bcd_in[7:4] = 4'd12;
`ifdef BCD_DECODER_ARBITER_DIGIT_CHECK_EN
    exp_q.push_back(mk(1, 4'hF, 1, 1'b1));
    wait_done(c);
    req = '0;
    check("invalid_len", c, 1);
`else
    exp_q.push_back(mk(1, 4'd12, HOLD, 1'b0));
    wait_done(c);
    req = '0;
    check("invalid_len", c, HOLD);
`endif
    repeat (4) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
